multicycle_ctrl_fsm: RTL and testbench

- Registered, parametrised control sequencer for the multi-cycle CPU: IF/ID/EXE/MEM/WB plus HALT.
- Extends the combinational next-state decode with:
  - instruction- and data-memory wait states
  - global stall
  - sticky halt with resume
  - illegal-opcode trap
  - opcode latching at ID
  - per-state write strobes and a retired-instruction counter
- Sits between the instruction register/opcode decode and the datapath enables.

---
 rtl/multicycle_ctrl_fsm_if.sv | 31 +++
 rtl/multicycle_ctrl_fsm.sv | 163 ++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/handshake bundle between the opcode decode, memories and the multi-cycle sequencer.
interface multicycle_ctrl_fsm_if #(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned CNT_W    = 32
);
  logic [OPCODE_W-1:0] Opcode;
  logic                imem_ready;
  logic                dmem_ready;
  logic                stall;
  logic                resume;
  logic [2:0]          cur_state;
  logic [2:0]          n_state;
  logic                ir_wr;
  logic                pc_wr;
  logic                reg_wr;
  logic                mem_wr;
  logic                retire;
  logic [CNT_W-1:0]    instret;
  logic                halted;
  logic                illegal;

  modport master (
    output Opcode, imem_ready, dmem_ready, stall, resume,
    input  cur_state, n_state, ir_wr, pc_wr, reg_wr, mem_wr, retire, instret, halted, illegal
  );

  modport slave (
    input  Opcode, imem_ready, dmem_ready, stall, resume,
    output cur_state, n_state, ir_wr, pc_wr, reg_wr, mem_wr, retire, instret, halted, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Registered IF/ID/EXE/MEM/WB/HALT sequencer with memory wait states, stall, halt/resume,
// illegal-opcode trap and a retired-instruction counter.
module multicycle_ctrl_fsm #(
  parameter int unsigned OPCODE_W     = 6,
  parameter int unsigned CNT_W        = 32,
  parameter bit          TRAP_ILLEGAL = 1'b1,
  parameter logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b110000),
  parameter logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b110001),
  parameter logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b110100),
  parameter logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b110101),
  parameter logic [OPCODE_W-1:0] OP_BGTZ = OPCODE_W'(6'b110110),
  parameter logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b111000),
  parameter logic [OPCODE_W-1:0] OP_JR   = OPCODE_W'(6'b111001),
  parameter logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(6'b111010),
  parameter logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(6'b111111),
  parameter logic [8:0][OPCODE_W-1:0] OP_ALU_LIST = {
    OPCODE_W'(6'b000010), OPCODE_W'(6'b010010), OPCODE_W'(6'b011000),
    OPCODE_W'(6'b000000), OPCODE_W'(6'b000001), OPCODE_W'(6'b100110),
    OPCODE_W'(6'b100111), OPCODE_W'(6'b010000), OPCODE_W'(6'b010001)
  }
) (
  input logic                  CLK,
  input logic                  Reset,
  multicycle_ctrl_fsm_if.slave bus
);

  localparam logic [2:0] StIf   = 3'b000;
  localparam logic [2:0] StId   = 3'b001;
  localparam logic [2:0] StExe  = 3'b010;
  localparam logic [2:0] StWb   = 3'b011;
  localparam logic [2:0] StMem  = 3'b100;
  localparam logic [2:0] StHalt = 3'b101;

  logic [2:0]          state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                illegal_q, illegal_d;
  logic [CNT_W-1:0]    instret_q;
  logic                ir_wr, pc_wr, reg_wr, mem_wr, retire;
  logic                hold;

  function automatic logic is_alu(input logic [OPCODE_W-1:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 9; i++) begin
      hit |= (op == OP_ALU_LIST[i]);
    end
    return hit;
  endfunction

  function automatic logic is_branch(input logic [OPCODE_W-1:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGTZ);
  endfunction

  function automatic logic is_mem(input logic [OPCODE_W-1:0] op);
    return (op == OP_SW) || (op == OP_LW);
  endfunction

  // Strobes are forced low while reset is asserted so nothing downstream fires during reset.
  assign hold = bus.stall | ~Reset;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    ir_wr     = 1'b0;
    pc_wr     = 1'b0;
    reg_wr    = 1'b0;
    mem_wr    = 1'b0;
    retire    = 1'b0;
    if (!hold) begin
      case (state_q)
        StIf: begin
          if (bus.imem_ready) begin
            state_d = StId;
            ir_wr   = 1'b1;
          end
        end
        StId: begin
          op_d = bus.Opcode;
          if ((bus.Opcode == OP_J) || (bus.Opcode == OP_JR) || (bus.Opcode == OP_JAL)) begin
            state_d = StIf;
            pc_wr   = 1'b1;
            retire  = 1'b1;
            reg_wr  = (bus.Opcode == OP_JAL);
          end else if (bus.Opcode == OP_HALT) begin
            state_d = StHalt;
            retire  = 1'b1;
          end else if (is_mem(bus.Opcode) || is_branch(bus.Opcode) || is_alu(bus.Opcode)) begin
            state_d = StExe;
          end else if (TRAP_ILLEGAL) begin
            state_d   = StHalt;
            illegal_d = 1'b1;
          end else begin
            state_d = StExe;
          end
        end
        StExe: begin
          if (is_branch(op_q)) begin
            state_d = StIf;
            pc_wr   = 1'b1;
            retire  = 1'b1;
          end else if (is_mem(op_q)) begin
            state_d = StMem;
          end else begin
            state_d = StWb;
          end
        end
        StMem: begin
          if (bus.dmem_ready) begin
            if (op_q == OP_SW) begin
              state_d = StIf;
              mem_wr  = 1'b1;
              pc_wr   = 1'b1;
              retire  = 1'b1;
            end else begin
              state_d = StWb;
            end
          end
        end
        StWb: begin
          state_d = StIf;
          reg_wr  = 1'b1;
          pc_wr   = 1'b1;
          retire  = 1'b1;
        end
        StHalt: begin
          if (bus.resume) begin
            state_d = StIf;
          end
        end
        default: state_d = StIf;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIf;
      op_q      <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign bus.cur_state = state_q;
  assign bus.n_state   = state_d;
  assign bus.ir_wr     = ir_wr;
  assign bus.pc_wr     = pc_wr;
  assign bus.reg_wr    = reg_wr;
  assign bus.mem_wr    = mem_wr;
  assign bus.retire    = retire;
  assign bus.instret   = instret_q;
  assign bus.halted    = (state_q == StHalt);
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench: dut0 traps illegal opcodes with a 4-bit counter; dut1 treats them as ALU ops.
module tb_multicycle_ctrl_fsm;

  logic CLK = 1'b0;
  logic Reset;
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  multicycle_ctrl_fsm_if #(.OPCODE_W(6), .CNT_W(4))  bus0 ();
  multicycle_ctrl_fsm_if #(.OPCODE_W(6), .CNT_W(32)) bus1 ();

  multicycle_ctrl_fsm #(.CNT_W(4), .TRAP_ILLEGAL(1'b1)) dut0 (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus0)
  );

  multicycle_ctrl_fsm #(.CNT_W(32), .TRAP_ILLEGAL(1'b0)) dut1 (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus1)
  );

  localparam logic [2:0] SIf = 3'd0, SId = 3'd1, SExe = 3'd2, SWb = 3'd3, SMem = 3'd4,
                         SHalt = 3'd5;
  // Strobe vector order: {ir_wr, pc_wr, reg_wr, mem_wr, retire}
  localparam logic [4:0] StbNone = 5'b00000, StbIr = 5'b10000, StbWb = 5'b01101,
                         StbSw = 5'b01011, StbBr = 5'b01001, StbJal = 5'b01101,
                         StbHalt = 5'b00001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] stb0();
    return {bus0.ir_wr, bus0.pc_wr, bus0.reg_wr, bus0.mem_wr, bus0.retire};
  endfunction

  task automatic drive(input logic [5:0] op, input logic im, input logic dm, input logic st,
                       input logic rs);
    bus0.Opcode = op; bus0.imem_ready = im; bus0.dmem_ready = dm;
    bus0.stall = st;  bus0.resume = rs;
    bus1.Opcode = op; bus1.imem_ready = im; bus1.dmem_ready = dm;
    bus1.stall = st;  bus1.resume = rs;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset = 1'b0;
    drive(6'b000000, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_state", bus0.cur_state, SIf);
    chk("rst_strobes", stb0(), StbNone);
    chk("rst_instret", bus0.instret, 0);
    chk("rst_illegal", bus0.illegal, 0);
    chk("rst_halted", bus0.halted, 0);
    @(negedge CLK);
    Reset = 1'b1;
    #1;

    // add: IF, ID, EXE, WB, IF
    chk("add_if_stb", stb0(), StbIr);
    chk("add_if_next", bus0.n_state, SId);
    tick();
    chk("add_id_state", bus0.cur_state, SId);
    chk("add_id_stb", stb0(), StbNone);
    tick();
    chk("add_exe_state", bus0.cur_state, SExe);
    chk("add_exe_stb", stb0(), StbNone);
    tick();
    chk("add_wb_state", bus0.cur_state, SWb);
    chk("add_wb_stb", stb0(), StbWb);
    chk("add_wb_instret", bus0.instret, 0);
    tick();
    chk("add_done_state", bus0.cur_state, SIf);
    chk("add_done_instret", bus0.instret, 1);

    // lw with three data wait cycles
    drive(6'b110001, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_wait_state", bus0.cur_state, SMem);
      chk("lw_wait_stb", stb0(), StbNone);
      tick();
    end
    chk("lw_mem4_state", bus0.cur_state, SMem);
    drive(6'b110001, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lw_ready_stb", stb0(), StbNone);
    chk("lw_ready_next", bus0.n_state, SWb);
    tick();
    chk("lw_wb_state", bus0.cur_state, SWb);
    tick();
    chk("lw_instret", bus0.instret, 2);

    // sw, opcode swapped to add during EXE
    drive(6'b110000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    drive(6'b000000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sw_exe_next", bus0.n_state, SMem);
    tick();
    chk("sw_mem_wait_stb", stb0(), StbNone);
    drive(6'b000000, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sw_mem_stb", stb0(), StbSw);
    chk("sw_mem_next", bus0.n_state, SIf);
    tick();
    chk("sw_done_state", bus0.cur_state, SIf);
    chk("sw_instret", bus0.instret, 3);

    // beq retires from EXE
    drive(6'b110100, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk("beq_exe_stb", stb0(), StbBr);
    chk("beq_exe_next", bus0.n_state, SIf);
    tick();
    chk("beq_instret", bus0.instret, 4);

    // jal retires from ID
    drive(6'b111010, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("jal_id_stb", stb0(), StbJal);
    chk("jal_id_next", bus0.n_state, SIf);
    tick();
    chk("jal_instret", bus0.instret, 5);

    // unknown opcode: dut0 traps, dut1 runs it as ALU
    drive(6'b101010, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ill_id_stb", stb0(), StbNone);
    chk("ill_id_next", bus0.n_state, SHalt);
    chk("ill_alu_next", bus1.n_state, SExe);
    tick();
    chk("ill_state", bus0.cur_state, SHalt);
    chk("ill_halted", bus0.halted, 1);
    chk("ill_flag", bus0.illegal, 1);
    chk("ill_instret", bus0.instret, 5);
    chk("ill_alu_flag", bus1.illegal, 0);
    tick();
    chk("ill_hold_state", bus0.cur_state, SHalt);
    chk("ill_alu_wb", bus1.cur_state, SWb);
    tick();
    chk("ill_alu_instret", bus1.instret, 6);
    drive(6'b101010, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("resume_next", bus0.n_state, SIf);
    tick();
    drive(6'b111111, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("resume_state", bus0.cur_state, SIf);
    chk("resume_illegal", bus0.illegal, 1);
    chk("resume_halted", bus0.halted, 0);

    // halt opcode retires and parks in HALT
    tick();
    chk("halt_id_stb", stb0(), StbHalt);
    tick();
    chk("halt_state", bus0.cur_state, SHalt);
    chk("halt_instret", bus0.instret, 6);
    drive(6'b000000, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    drive(6'b000000, 1'b1, 1'b0, 1'b0, 1'b0);

    // stall held five cycles in EXE
    tick(); tick();
    drive(6'b000000, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_state", bus0.cur_state, SExe);
      chk("stall_stb", stb0(), StbNone);
      tick();
    end
    drive(6'b000000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stall_release_next", bus0.n_state, SWb);
    tick(); tick();
    chk("stall_instret", bus0.instret, 7);

    // 16 jumps wrap the 4-bit counter through 15 -> 0
    drive(6'b111000, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick(); tick();
      chk("wrap_instret", bus0.instret, (7 + i + 1) % 16);
    end

    // reset during MEM aborts the load
    drive(6'b110001, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("abort_pre_state", bus0.cur_state, SMem);
    #2;
    Reset = 1'b0;
    #1;
    chk("abort_state", bus0.cur_state, SIf);
    chk("abort_instret", bus0.instret, 0);
    chk("abort_illegal", bus0.illegal, 0);
    chk("abort_stb", stb0(), StbNone);
    @(negedge CLK);
    Reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
